// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// downstream stall hold, branch flush and a saturating bubble counter.
module id_ex_stage_reg #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            id_wb,
  input  logic [2:0]            id_m,
  input  logic [3:0]            id_ex,
  input  logic                  id_valid,
  input  logic [DATA_W-1:0]     id_pc4,
  input  logic [DATA_W-1:0]     id_rs_data,
  input  logic [DATA_W-1:0]     id_rt_data,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  ex_stall,
  input  logic                  flush,
  output logic [1:0]            ex_wb,
  output logic [2:0]            ex_m,
  output logic [3:0]            ex_ex,
  output logic                  ex_valid,
  output logic [DATA_W-1:0]     ex_pc4,
  output logic [DATA_W-1:0]     ex_rs_data,
  output logic [DATA_W-1:0]     ex_rt_data,
  output logic [DATA_W-1:0]     ex_imm,
  output logic [REG_ADDR_W-1:0] ex_rs,
  output logic [REG_ADDR_W-1:0] ex_rt,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  hazard_stall,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic [CNT_W-1:0]      bubble_count
);

  logic [1:0]            wb_q, wb_d;
  logic [2:0]            m_q, m_d;
  logic [3:0]            ex_q, ex_d;
  logic                  valid_q, valid_d;
  logic [DATA_W-1:0]     pc4_q, pc4_d;
  logic [DATA_W-1:0]     rs_data_q, rs_data_d;
  logic [DATA_W-1:0]     rt_data_q, rt_data_d;
  logic [DATA_W-1:0]     imm_q, imm_d;
  logic [REG_ADDR_W-1:0] rs_q, rs_d;
  logic [REG_ADDR_W-1:0] rt_q, rt_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0]      bubble_count_q, bubble_count_d;

  // A load in EX whose destination feeds the ID instruction; $0 never hazards.
  assign hazard_stall = valid_q & m_q[1] & (rt_q != '0) & id_valid &
                        ((rt_q == id_rs) | (rt_q == id_rt));
  assign pc_write     = ~hazard_stall & ~ex_stall;
  assign if_id_write  = ~hazard_stall & ~ex_stall;

  always_comb begin
    wb_d           = wb_q;
    m_d            = m_q;
    ex_d           = ex_q;
    valid_d        = valid_q;
    pc4_d          = pc4_q;
    rs_data_d      = rs_data_q;
    rt_data_d      = rt_data_q;
    imm_d          = imm_q;
    rs_d           = rs_q;
    rt_d           = rt_q;
    rd_d           = rd_q;
    bubble_count_d = bubble_count_q;
    if (flush || (!ex_stall && hazard_stall)) begin
      wb_d      = '0;
      m_d       = '0;
      ex_d      = '0;
      valid_d   = 1'b0;
      pc4_d     = '0;
      rs_data_d = '0;
      rt_data_d = '0;
      imm_d     = '0;
      rs_d      = '0;
      rt_d      = '0;
      rd_d      = '0;
      if (!flush && (bubble_count_q != '1))
        bubble_count_d = bubble_count_q + 1'b1;
    end else if (!ex_stall) begin
      wb_d      = id_valid ? id_wb : 2'b00;
      m_d       = id_valid ? id_m  : 3'b000;
      ex_d      = id_valid ? id_ex : 4'b0000;
      valid_d   = id_valid;
      pc4_d     = id_pc4;
      rs_data_d = id_rs_data;
      rt_data_d = id_rt_data;
      imm_d     = id_imm;
      rs_d      = id_rs;
      rt_d      = id_rt;
      rd_d      = id_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q           <= '0;
      m_q            <= '0;
      ex_q           <= '0;
      valid_q        <= 1'b0;
      pc4_q          <= '0;
      rs_data_q      <= '0;
      rt_data_q      <= '0;
      imm_q          <= '0;
      rs_q           <= '0;
      rt_q           <= '0;
      rd_q           <= '0;
      bubble_count_q <= '0;
    end else begin
      wb_q           <= wb_d;
      m_q            <= m_d;
      ex_q           <= ex_d;
      valid_q        <= valid_d;
      pc4_q          <= pc4_d;
      rs_data_q      <= rs_data_d;
      rt_data_q      <= rt_data_d;
      imm_q          <= imm_d;
      rs_q           <= rs_d;
      rt_q           <= rt_d;
      rd_q           <= rd_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign ex_wb        = wb_q;
  assign ex_m         = m_q;
  assign ex_ex        = ex_q;
  assign ex_valid     = valid_q;
  assign ex_pc4       = pc4_q;
  assign ex_rs_data   = rs_data_q;
  assign ex_rt_data   = rt_data_q;
  assign ex_imm       = imm_q;
  assign ex_rs        = rs_q;
  assign ex_rt        = rt_q;
  assign ex_rd        = rd_q;
  assign bubble_count = bubble_count_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg; a second instance with a 2-bit counter
// shares the stimulus so counter saturation can be reached quickly.
module tb_id_ex_stage_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  idWb;
  logic [2:0]  idM;
  logic [3:0]  idEx;
  logic        idValid;
  logic [31:0] idPc4, idRsData, idRtData, idImm;
  logic [4:0]  idRs, idRt, idRd;
  logic        exStall, flush;

  logic [1:0]  exWb, exWb2;
  logic [2:0]  exM, exM2;
  logic [3:0]  exEx, exEx2;
  logic        exValid, exValid2;
  logic [31:0] exPc4, exRsData, exRtData, exImm;
  logic [31:0] exPc42, exRsData2, exRtData2, exImm2;
  logic [4:0]  exRs, exRt, exRd, exRs2, exRt2, exRd2;
  logic        hazardStall, pcWrite, ifIdWrite;
  logic        hazardStall2, pcWrite2, ifIdWrite2;
  logic [15:0] bubbleCount;
  logic [1:0]  bubbleCount2;

  int checkCount = 0;
  int failCount  = 0;

  always #5 clk = ~clk;

  id_ex_stage_reg u_dut (
    .clk(clk), .rst(rst), .id_wb(idWb), .id_m(idM), .id_ex(idEx), .id_valid(idValid),
    .id_pc4(idPc4), .id_rs_data(idRsData), .id_rt_data(idRtData), .id_imm(idImm),
    .id_rs(idRs), .id_rt(idRt), .id_rd(idRd), .ex_stall(exStall), .flush(flush),
    .ex_wb(exWb), .ex_m(exM), .ex_ex(exEx), .ex_valid(exValid), .ex_pc4(exPc4),
    .ex_rs_data(exRsData), .ex_rt_data(exRtData), .ex_imm(exImm),
    .ex_rs(exRs), .ex_rt(exRt), .ex_rd(exRd), .hazard_stall(hazardStall),
    .pc_write(pcWrite), .if_id_write(ifIdWrite), .bubble_count(bubbleCount)
  );

  id_ex_stage_reg #(.CNT_W(2)) u_dut_small (
    .clk(clk), .rst(rst), .id_wb(idWb), .id_m(idM), .id_ex(idEx), .id_valid(idValid),
    .id_pc4(idPc4), .id_rs_data(idRsData), .id_rt_data(idRtData), .id_imm(idImm),
    .id_rs(idRs), .id_rt(idRt), .id_rd(idRd), .ex_stall(exStall), .flush(flush),
    .ex_wb(exWb2), .ex_m(exM2), .ex_ex(exEx2), .ex_valid(exValid2), .ex_pc4(exPc42),
    .ex_rs_data(exRsData2), .ex_rt_data(exRtData2), .ex_imm(exImm2),
    .ex_rs(exRs2), .ex_rt(exRt2), .ex_rd(exRd2), .hazard_stall(hazardStall2),
    .pc_write(pcWrite2), .if_id_write(ifIdWrite2), .bubble_count(bubbleCount2)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Drives the ID-stage inputs, then lets combinational outputs settle.
  task automatic applyStimulus(input logic v, input logic [1:0] wb, input logic [2:0] m,
                               input logic [3:0] ex, input logic [31:0] pc4,
                               input logic [31:0] rsd, input logic [31:0] rtd,
                               input logic [31:0] imm, input logic [4:0] rs,
                               input logic [4:0] rt, input logic [4:0] rd);
    idValid = v; idWb = wb; idM = m; idEx = ex; idPc4 = pc4;
    idRsData = rsd; idRtData = rtd; idImm = imm; idRs = rs; idRt = rt; idRd = rd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_wb"}, exWb, 0);
    checkOutput({tag, "_m"}, exM, 0);
    checkOutput({tag, "_ex"}, exEx, 0);
    checkOutput({tag, "_valid"}, exValid, 0);
    checkOutput({tag, "_pc4"}, exPc4, 0);
    checkOutput({tag, "_rsdata"}, exRsData, 0);
    checkOutput({tag, "_rtdata"}, exRtData, 0);
    checkOutput({tag, "_imm"}, exImm, 0);
    checkOutput({tag, "_rs"}, exRs, 0);
    checkOutput({tag, "_rt"}, exRt, 0);
    checkOutput({tag, "_rd"}, exRd, 0);
  endtask

  initial begin
    rst = 1'b1; exStall = 1'b0; flush = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    checkAllZero("reset");
    checkOutput("reset_bubbles", bubbleCount, 0);
    checkOutput("reset_pcwrite", pcWrite, 1);
    checkOutput("reset_ifidwrite", ifIdWrite, 1);
    checkOutput("reset_hazard", hazardStall, 0);
    rst = 1'b0;

    // R-type passes through with one cycle latency
    applyStimulus(1, 2'b10, 3'b000, 4'b1100, 32'h104, 32'h1234, 32'h5678, 32'h10, 5'd1, 5'd2, 5'd3);
    tick();
    checkOutput("rtype_wb", exWb, 2'b10);
    checkOutput("rtype_m", exM, 3'b000);
    checkOutput("rtype_ex", exEx, 4'b1100);
    checkOutput("rtype_valid", exValid, 1);
    checkOutput("rtype_pc4", exPc4, 32'h104);
    checkOutput("rtype_rsdata", exRsData, 32'h1234);
    checkOutput("rtype_rtdata", exRtData, 32'h5678);
    checkOutput("rtype_imm", exImm, 32'h10);
    checkOutput("rtype_rs", exRs, 1);
    checkOutput("rtype_rt", exRt, 2);
    checkOutput("rtype_rd", exRd, 3);

    // Invalid ID slot: control forced to zero, data still loads
    applyStimulus(0, 2'b11, 3'b111, 4'b1111, 32'h200, 32'hAAAA, 32'hBBBB, 32'hCC, 5'd7, 5'd8, 5'd9);
    tick();
    checkOutput("inv_wb", exWb, 0);
    checkOutput("inv_m", exM, 0);
    checkOutput("inv_ex", exEx, 0);
    checkOutput("inv_valid", exValid, 0);
    checkOutput("inv_rsdata", exRsData, 32'hAAAA);
    checkOutput("inv_rd", exRd, 9);

    // Load-use: lw rt=5 then add rs=5
    applyStimulus(1, 2'b11, 3'b010, 4'b0011, 32'h108, 32'h100, 32'h0, 32'h4, 5'd1, 5'd5, 5'd0);
    tick();
    checkOutput("lw_m", exM, 3'b010);
    applyStimulus(1, 2'b10, 3'b000, 4'b1100, 32'h10C, 32'h33, 32'h44, 32'h0, 5'd5, 5'd6, 5'd7);
    checkOutput("lu_hazard", hazardStall, 1);
    checkOutput("lu_pcwrite", pcWrite, 0);
    checkOutput("lu_ifidwrite", ifIdWrite, 0);
    tick();
    checkAllZero("bubble");
    checkOutput("bubble_count1", bubbleCount, 1);
    checkOutput("bubble_hazard_gone", hazardStall, 0);
    checkOutput("bubble_pcwrite", pcWrite, 1);
    tick();
    checkOutput("add_wb", exWb, 2'b10);
    checkOutput("add_ex", exEx, 4'b1100);
    checkOutput("add_valid", exValid, 1);
    checkOutput("add_rsdata", exRsData, 32'h33);
    checkOutput("add_rs", exRs, 5);
    checkOutput("add_rd", exRd, 7);
    checkOutput("add_count", bubbleCount, 1);

    // Load to $0 followed by a use of $0: no hazard
    applyStimulus(1, 2'b11, 3'b010, 4'b0011, 32'h110, 32'h0, 32'h0, 32'h8, 5'd2, 5'd0, 5'd0);
    tick();
    applyStimulus(1, 2'b10, 3'b000, 4'b1100, 32'h114, 32'h55, 32'h66, 32'h0, 5'd0, 5'd0, 5'd4);
    checkOutput("zero_hazard", hazardStall, 0);
    checkOutput("zero_pcwrite", pcWrite, 1);
    tick();
    checkOutput("zero_valid", exValid, 1);
    checkOutput("zero_rsdata", exRsData, 32'h55);
    checkOutput("zero_count", bubbleCount, 1);

    // Downstream stall holds everything for 3 cycles
    exStall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 2'b01, 3'b001, 4'b0001, 32'h300 + i, 32'h900 + i, 32'h1, 32'h2, 5'd10, 5'd11, 5'd12);
      checkOutput("stall_pcwrite", pcWrite, 0);
      checkOutput("stall_ifidwrite", ifIdWrite, 0);
      tick();
      checkOutput("stall_wb", exWb, 2'b10);
      checkOutput("stall_rsdata", exRsData, 32'h55);
      checkOutput("stall_rd", exRd, 4);
    end
    exStall = 1'b0;

    // Stall during a hazard holds the load and does not count
    applyStimulus(1, 2'b11, 3'b010, 4'b0011, 32'h118, 32'h0, 32'h0, 32'h0, 5'd1, 5'd9, 5'd0);
    tick();
    applyStimulus(1, 2'b10, 3'b000, 4'b1100, 32'h11C, 32'h77, 32'h88, 32'h0, 5'd9, 5'd3, 5'd8);
    exStall = 1'b1;
    checkOutput("stallhz_hazard", hazardStall, 1);
    tick();
    checkOutput("stallhz_m", exM, 3'b010);
    checkOutput("stallhz_count", bubbleCount, 1);
    exStall = 1'b0;

    // Flush wins over the hazard: cleared, no count
    flush = 1'b1;
    #1;
    checkOutput("flushhz_hazard", hazardStall, 1);
    checkOutput("flushhz_pcwrite", pcWrite, 0);
    tick();
    flush = 1'b0;
    checkAllZero("flush");
    checkOutput("flush_count", bubbleCount, 1);
    tick();
    checkOutput("postflush_rsdata", exRsData, 32'h77);
    checkOutput("postflush_valid", exValid, 1);

    // Reset mid-bubble clears with no residual hazard
    applyStimulus(1, 2'b11, 3'b010, 4'b0011, 32'h120, 32'h0, 32'h0, 32'h0, 5'd1, 5'd5, 5'd0);
    tick();
    applyStimulus(1, 2'b10, 3'b000, 4'b1100, 32'h124, 32'h1, 32'h2, 32'h0, 5'd5, 5'd6, 5'd7);
    checkOutput("rstmid_hazard", hazardStall, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkAllZero("rstmid");
    checkOutput("rstmid_count", bubbleCount, 0);
    checkOutput("rstmid_count_small", bubbleCount2, 0);
    checkOutput("rstmid_nohazard", hazardStall, 0);

    // Four bubbles: wide counter reaches 4, 2-bit counter saturates at 3
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 2'b11, 3'b010, 4'b0011, 32'h200, 32'h0, 32'h0, 32'h0, 5'd1, 5'd5, 5'd0);
      tick();
      applyStimulus(1, 2'b10, 3'b000, 4'b1100, 32'h204, 32'h1, 32'h2, 32'h0, 5'd5, 5'd6, 5'd7);
      tick();
      checkOutput("sat_count", bubbleCount, i + 1);
      checkOutput("sat_count_small", bubbleCount2, (i < 3) ? i + 1 : 3);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
